shift_sequencer: RTL and testbench

Multi-step shift engine that sits directly downstream of the 4-bit one-step shifter stage and closes the loop around it. It captures an operand, applies the shifter's single-step operation once per clock for a programmed number of steps, and holds the result. A start/busy/done handshake lets a controller issue N-step shifts and rotates without driving the select lines itself.

---
 rtl/shift_sequencer_if.sv | 15 +
 rtl/shift_sequencer.sv | 55 +++++
 tb/tb_shift_sequencer.sv | 104 ++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: start/busy/done handshake and operand bus for the multi-step shift engine.
interface shift_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             start;
    logic [WIDTH-1:0] din;
    logic [1:0]       op;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;
    modport master (output start, din, op, count, input busy, done, dout);
    modport slave  (input start, din, op, count, output busy, done, dout);
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: applies a latched one-step shift/rotate op for a programmed number of clocks.
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input logic              clk,
    input logic              rst,
    shift_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] r, r_n, stepped;
    logic [CNT_W-1:0] rem, rem_n;
    logic [1:0]       op_q, op_n;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            r     <= '0;
            rem   <= '0;
            op_q  <= 2'b00;
        end else begin
            state <= state_n;
            r     <= r_n;
            rem   <= rem_n;
            op_q  <= op_n;
        end
    end
    always_comb begin
        stepped = op_q == 2'b01 ? {r[WIDTH-2:0], 1'b1} :
                  op_q == 2'b10 ? {1'b1, r[WIDTH-1:1]} :
                  op_q == 2'b11 ? {r[0], r[WIDTH-1:1]} : r;
    end
    // DONE accepts start exactly like IDLE, giving back-to-back operation
    always_comb begin
        state_n = state;
        r_n     = r;
        rem_n   = rem;
        op_n    = op_q;
        if (state == RUN) begin
            r_n     = stepped;
            rem_n   = rem != '0 ? rem - 1'b1 : rem;
            state_n = rem <= CNT_W'(1) ? DONE : RUN;
        end else if (bus.start) begin
            r_n     = bus.din;
            op_n    = bus.op;
            rem_n   = bus.count;
            state_n = bus.count != '0 ? RUN : DONE;
        end else if (state == DONE) begin
            state_n = IDLE;
        end
    end
    assign bus.busy = state == RUN;
    assign bus.done = state == DONE;
    assign bus.dout = r;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed steps with hand-computed dout/busy/done after every edge.
module tb_shift_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    shift_sequencer_if #(.WIDTH(4), .CNT_W(3)) bus ();
    shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [3:0] d, input logic b, input logic dn);
        checks++;
        assert ({bus.dout, bus.busy, bus.done} === {d, b, dn}) else begin
            failures++;
            $error("FAIL %s dout/busy/done observed=%b/%b/%b expected=%b/%b/%b",
                   tag, bus.dout, bus.busy, bus.done, d, b, dn);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic go(input logic [3:0] d, input logic [1:0] o, input logic [2:0] c);
        bus.start = 1'b1;
        bus.din   = d;
        bus.op    = o;
        bus.count = c;
        tick();
        bus.start = 1'b0;
    endtask
    initial begin
        bus.start = 1'b0;
        bus.din   = 4'b0000;
        bus.op    = 2'b00;
        bus.count = 3'd0;
        #2 rst = 1'b1;
        #1 chk("reset_async", 4'b0000, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_stable", 4'b0000, 1'b0, 1'b0);
        end
        go(4'b0011, 2'b01, 3'd2);
        chk("shl_load", 4'b0011, 1'b1, 1'b0);
        tick(); chk("shl_s1", 4'b0111, 1'b1, 1'b0);
        tick(); chk("shl_done", 4'b1111, 1'b0, 1'b1);
        tick(); chk("shl_hold", 4'b1111, 1'b0, 1'b0);
        go(4'b1000, 2'b10, 3'd1);
        chk("shr_load", 4'b1000, 1'b1, 1'b0);
        tick(); chk("shr_done", 4'b1100, 1'b0, 1'b1);
        tick(); chk("shr_hold", 4'b1100, 1'b0, 1'b0);
        go(4'b0001, 2'b11, 3'd4);
        chk("rot_load", 4'b0001, 1'b1, 1'b0);
        tick(); chk("rot_s1", 4'b1000, 1'b1, 1'b0);
        tick(); chk("rot_s2", 4'b0100, 1'b1, 1'b0);
        tick(); chk("rot_s3", 4'b0010, 1'b1, 1'b0);
        tick(); chk("rot_done", 4'b0001, 1'b0, 1'b1);
        tick(); chk("rot_hold", 4'b0001, 1'b0, 1'b0);
        go(4'b1010, 2'b01, 3'd0);
        chk("zero_done", 4'b1010, 1'b0, 1'b1);
        tick(); chk("zero_hold", 4'b1010, 1'b0, 1'b0);
        go(4'b0110, 2'b00, 3'd7);
        chk("hold_load", 4'b0110, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("hold_run", 4'b0110, 1'b1, 1'b0);
        end
        tick(); chk("hold_done", 4'b0110, 1'b0, 1'b1);
        tick(); chk("hold_idle", 4'b0110, 1'b0, 1'b0);
        // live inputs disturbed during RUN; start stays high into DONE for a back-to-back op
        go(4'b0000, 2'b01, 3'd3);
        bus.start = 1'b1;
        bus.din   = 4'b0101;
        bus.op    = 2'b11;
        bus.count = 3'd1;
        chk("intf_load", 4'b0000, 1'b1, 1'b0);
        tick(); chk("intf_s1", 4'b0001, 1'b1, 1'b0);
        tick(); chk("intf_s2", 4'b0011, 1'b1, 1'b0);
        tick(); chk("intf_done", 4'b0111, 1'b0, 1'b1);
        tick(); chk("b2b_load", 4'b0101, 1'b1, 1'b0);
        bus.start = 1'b0;
        tick(); chk("b2b_done", 4'b1010, 1'b0, 1'b1);
        tick(); chk("b2b_idle", 4'b1010, 1'b0, 1'b0);
        go(4'b0011, 2'b01, 3'd5);
        chk("abort_load", 4'b0011, 1'b1, 1'b0);
        tick(); chk("abort_s1", 4'b0111, 1'b1, 1'b0);
        tick(); chk("abort_s2", 4'b1111, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 chk("abort_async", 4'b0000, 1'b0, 1'b0);
        tick(); chk("abort_held", 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_done", 4'b0000, 1'b0, 1'b0);
        end
        go(4'b0011, 2'b01, 3'd1);
        chk("post_load", 4'b0011, 1'b1, 1'b0);
        tick(); chk("post_done", 4'b0111, 1'b0, 1'b1);
        tick(); chk("post_idle", 4'b0111, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
